// File: rtl/csr_trap_if.sv
// CSR access port between the execute stage and the machine-mode CSR/trap unit.
// The execute stage is the master; the CSR unit answers combinationally.
interface csr_trap_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_data_in;
  logic [1:0]      csr_cntrl;
  logic            csr_rd;
  logic            csr_wr;
  logic [XLEN-1:0] csr_data_out;
  logic            illegal_csr;

  modport master (
    output csr_addr, csr_data_in, csr_cntrl, csr_rd, csr_wr,
    input  csr_data_out, illegal_csr
  );

  modport slave (
    input  csr_addr, csr_data_in, csr_cntrl, csr_rd, csr_wr,
    output csr_data_out, illegal_csr
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: M-mode trap CSRs, counters,
// exception/interrupt arbitration, trap entry, mret and fetch redirect.
module csr_trap_unit #(
  parameter int          XLEN        = 32,
  parameter int          IRQ_COUNT   = 4,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [XLEN-1:0]                        pc,
  input  logic [XLEN-1:0]                        instr,
  input  logic                                   exception,
  input  logic [7:0]                             exception_code,
  input  logic                                   mret,
  input  logic                                   instr_retire,
  input  logic                                   irq_ext,
  input  logic                                   irq_timer,
  input  logic [(IRQ_COUNT > 0 ? IRQ_COUNT : 1)-1:0] irq_local,
  csr_trap_if.slave                              csr,
  output logic                                   trap_taken,
  output logic [XLEN-1:0]                        trap_pc,
  output logic [XLEN-1:0]                        csr_mepc
);

  localparam logic [31:0] MIE_MASK = (((32'h1 << IRQ_COUNT) - 32'h1) << 16) | 32'h0000_0880;

  logic        mstatus_mie_reg, mstatus_mie_next;
  logic        mstatus_mpie_reg, mstatus_mpie_next;
  logic [31:0] mie_reg, mie_next;
  logic [31:0] mtvec_reg, mtvec_next;
  logic [31:0] mscratch_reg, mscratch_next;
  logic [31:0] mepc_reg, mepc_next;
  logic [31:0] mcause_reg, mcause_next;
  logic [31:0] mtval_reg, mtval_next;
  logic        exc_prev_reg;

  logic [31:0] cnt_lo [2];
  logic [31:0] cnt_hi [2];

  logic [31:0] mstatus, mip, irq_pend, rdata, wdata, vec_base;
  logic        valid, read_only, illegal, wr_en;
  logic        exc_req, irq_req, trap;
  logic [4:0]  irq_cause;

  assign mstatus = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

  always_comb begin
    mip     = '0;
    mip[11] = irq_ext;
    mip[7]  = irq_timer;
    for (int i = 0; i < IRQ_COUNT; i++) mip[16+i] = irq_local[i];
  end

  always_comb begin
    rdata     = '0;
    valid     = 1'b1;
    read_only = 1'b0;
    case (csr.csr_addr)
      12'h300: rdata = mstatus;
      12'h304: rdata = mie_reg;
      12'h305: rdata = mtvec_reg;
      12'h340: rdata = mscratch_reg;
      12'h341: rdata = mepc_reg;
      12'h342: rdata = mcause_reg;
      12'h343: rdata = mtval_reg;
      12'h344: begin rdata = mip; read_only = 1'b1; end
      12'hB00: rdata = cnt_lo[0];
      12'hB02: rdata = cnt_lo[1];
      12'hB80: begin rdata = cnt_hi[0]; valid = (CNT_WIDTH == 64); end
      12'hB82: begin rdata = cnt_hi[1]; valid = (CNT_WIDTH == 64); end
      12'hF14: read_only = 1'b1;
      default: valid = 1'b0;
    endcase
  end

  assign illegal          = ~reset & (csr.csr_rd | csr.csr_wr) & (~valid | (csr.csr_wr & read_only));
  assign csr.illegal_csr  = illegal;
  assign csr.csr_data_out = (reset | illegal) ? '0 : rdata;

  always_comb begin
    case (csr.csr_cntrl)
      2'b00:   wdata = csr.csr_data_in;
      2'b01:   wdata = rdata | csr.csr_data_in;
      2'b10:   wdata = rdata & ~csr.csr_data_in;
      default: wdata = rdata;
    endcase
  end

  // A no-op mode is not a write, so it must not suppress a counter increment.
  assign wr_en = csr.csr_wr & ~illegal & ~reset & (csr.csr_cntrl != 2'b11);

  // Trap arbitration: the last matching assignment is the highest priority.
  assign exc_req  = exception & ~exc_prev_reg;
  assign irq_pend = mip & mie_reg;
  assign irq_req  = mstatus_mie_reg & (|irq_pend);
  assign trap     = exc_req | irq_req;

  always_comb begin
    irq_cause = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (irq_pend[16+i]) irq_cause = 5'(16 + i);
    end
    if (irq_pend[7])  irq_cause = 5'd7;
    if (irq_pend[11]) irq_cause = 5'd11;
  end

  assign vec_base   = {mtvec_reg[31:2], 2'b00};
  assign trap_taken = ~reset & trap;
  assign trap_pc    = (~exc_req & mtvec_reg[0]) ? vec_base + {25'b0, irq_cause, 2'b00} : vec_base;
  assign csr_mepc   = mepc_reg;

  always_comb begin
    mstatus_mie_next  = mstatus_mie_reg;
    mstatus_mpie_next = mstatus_mpie_reg;
    mie_next          = mie_reg;
    mtvec_next        = mtvec_reg;
    mscratch_next     = mscratch_reg;
    mepc_next         = mepc_reg;
    mcause_next       = mcause_reg;
    mtval_next        = mtval_reg;
    if (wr_en) begin
      case (csr.csr_addr)
        12'h300: begin mstatus_mie_next = wdata[3]; mstatus_mpie_next = wdata[7]; end
        12'h304: mie_next      = wdata & MIE_MASK;
        12'h305: mtvec_next    = wdata & ~32'h2;
        12'h340: mscratch_next = wdata;
        12'h341: mepc_next     = wdata & ~32'h3;
        12'h342: mcause_next   = wdata;
        12'h343: mtval_next    = wdata;
        default: ;
      endcase
    end
    if (mret && !trap) begin
      mstatus_mie_next  = mstatus_mpie_reg;
      mstatus_mpie_next = 1'b1;
    end
    // Trap entry overrides any same-cycle write to the trap-state CSRs.
    if (trap) begin
      mepc_next         = pc & ~32'h3;
      mstatus_mpie_next = mstatus_mie_reg;
      mstatus_mie_next  = 1'b0;
      if (exc_req) begin
        mcause_next = {24'b0, exception_code};
        mtval_next  = (exception_code == 8'd2) ? instr : '0;
      end else begin
        mcause_next = {1'b1, 26'b0, irq_cause};
        mtval_next  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= MTVEC_RESET;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      exc_prev_reg     <= 1'b0;
    end else begin
      mstatus_mie_reg  <= mstatus_mie_next;
      mstatus_mpie_reg <= mstatus_mpie_next;
      mie_reg          <= mie_next;
      mtvec_reg        <= mtvec_next;
      mscratch_reg     <= mscratch_next;
      mepc_reg         <= mepc_next;
      mcause_reg       <= mcause_next;
      mtval_reg        <= mtval_next;
      exc_prev_reg     <= exception;
    end
  end

  // gi=0 is mcycle, gi=1 is minstret; a write to either half replaces that cycle's increment.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 inc, wr_lo;

    assign inc   = (gi == 0) ? 1'b1 : instr_retire;
    assign wr_lo = wr_en & (csr.csr_addr == ((gi == 0) ? 12'hB00 : 12'hB02));

    if (CNT_WIDTH == 64) begin : g_w64
      logic wr_hi;
      assign wr_hi = wr_en & (csr.csr_addr == ((gi == 0) ? 12'hB80 : 12'hB82));
      always_comb begin
        count_next = count_reg + {{(CNT_WIDTH-1){1'b0}}, inc};
        if (wr_lo) count_next = {count_reg[CNT_WIDTH-1:32], wdata};
        if (wr_hi) count_next = {wdata, count_reg[31:0]};
      end
      assign cnt_lo[gi] = count_reg[31:0];
      assign cnt_hi[gi] = count_reg[CNT_WIDTH-1:32];
    end else begin : g_w32
      always_comb begin
        count_next = count_reg + {{(CNT_WIDTH-1){1'b0}}, inc};
        if (wr_lo) count_next = wdata;
      end
      assign cnt_lo[gi] = count_reg;
      assign cnt_hi[gi] = '0;
    end

    always_ff @(posedge clk) begin
      if (reset) count_reg <= '0;
      else       count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed-vector bench for csr_trap_unit: a 64-bit-counter instance with a
// non-zero mtvec reset, plus a 32-bit-counter instance for the address-map boundary.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instr;
  logic        exception, mret, instr_retire, irq_ext, irq_timer;
  logic [7:0]  exception_code;
  logic [3:0]  irq_local;
  logic        trap_taken, trap32;
  logic [31:0] trap_pc, csr_mepc, tpc32, mepc32;

  int vectors     = 0;
  int miscompares = 0;

  csr_trap_if #(.XLEN(32)) bus ();
  csr_trap_if #(.XLEN(32)) bus32 ();

  assign bus32.csr_addr    = bus.csr_addr;
  assign bus32.csr_data_in = bus.csr_data_in;
  assign bus32.csr_cntrl   = bus.csr_cntrl;
  assign bus32.csr_rd      = bus.csr_rd;
  assign bus32.csr_wr      = bus.csr_wr;

  csr_trap_unit #(.XLEN(32), .IRQ_COUNT(4), .CNT_WIDTH(64), .MTVEC_RESET(32'h0000_0200)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .exception(exception),
    .exception_code(exception_code), .mret(mret), .instr_retire(instr_retire),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_local(irq_local), .csr(bus),
    .trap_taken(trap_taken), .trap_pc(trap_pc), .csr_mepc(csr_mepc)
  );

  csr_trap_unit #(.XLEN(32), .IRQ_COUNT(4), .CNT_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .exception(exception),
    .exception_code(exception_code), .mret(mret), .instr_retire(instr_retire),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_local(irq_local), .csr(bus32),
    .trap_taken(trap32), .trap_pc(tpc32), .csr_mepc(mepc32)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic rd_csr(input logic [11:0] a, output logic [31:0] d, output logic ill, output logic ill32);
    @(negedge clk);
    bus.csr_addr = a;
    bus.csr_rd   = 1'b1;
    bus.csr_wr   = 1'b0;
    #2;
    d     = bus.csr_data_out;
    ill   = bus.illegal_csr;
    ill32 = bus32.illegal_csr;
    @(posedge clk);
    #1 bus.csr_rd = 1'b0;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] mode, output logic ill);
    @(negedge clk);
    bus.csr_addr    = a;
    bus.csr_data_in = d;
    bus.csr_cntrl   = mode;
    bus.csr_wr      = 1'b1;
    #2 ill = bus.illegal_csr;
    @(posedge clk);
    #1 bus.csr_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        ill, ill32;
    int          pulses;

    reset = 1'b1; pc = '0; instr = '0; exception = 1'b0; exception_code = '0;
    mret = 1'b0; instr_retire = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_local = '0;
    bus.csr_addr = '0; bus.csr_data_in = '0; bus.csr_cntrl = 2'b11; bus.csr_rd = 1'b0; bus.csr_wr = 1'b0;
    repeat (3) @(posedge clk);

    // Outputs held low while reset is asserted
    rd_csr(12'h300, d, ill, ill32);
    check_vec("rst_hold_data", d, 32'h0);
    rd_csr(12'h7C0, d, ill, ill32);
    check_vec("rst_hold_illegal", {31'b0, ill}, 32'h0);
    @(negedge clk); exception = 1'b1;
    #2 check_vec("rst_hold_trap", {31'b0, trap_taken}, 32'h0);
    @(posedge clk); #1 exception = 1'b0;

    @(posedge clk); #1 reset = 1'b0;
    rd_csr(12'hB00, d, ill, ill32); check_vec("mcycle_0", d, 32'd0);
    rd_csr(12'hB00, d, ill, ill32); check_vec("mcycle_1", d, 32'd1);
    rd_csr(12'hB00, d, ill, ill32); check_vec("mcycle_2", d, 32'd2);
    rd_csr(12'h300, d, ill, ill32); check_vec("mstatus_reset", d, 32'h0000_1800);
    rd_csr(12'h305, d, ill, ill32); check_vec("mtvec_reset", d, 32'h0000_0200);

    // Illegal-instruction exception held for 3 cycles, direct mode
    wr_csr(12'h305, 32'h0000_0100, 2'b00, ill);
    wr_csr(12'h300, 32'h0000_0008, 2'b01, ill);
    pc = 32'h40; instr = 32'hDEAD_BEEF; exception_code = 8'd2;
    pulses = 0;
    @(negedge clk); exception = 1'b1;
    repeat (3) begin
      #2;
      if (trap_taken) begin
        pulses++;
        check_vec("exc_trap_pc", trap_pc, 32'h0000_0100);
      end
      @(negedge clk);
    end
    exception = 1'b0;
    check_vec("exc_pulses", pulses, 32'd1);
    rd_csr(12'h341, d, ill, ill32); check_vec("exc_mepc", d, 32'h40);
    check_vec("exc_csr_mepc", csr_mepc, 32'h40);
    rd_csr(12'h342, d, ill, ill32); check_vec("exc_mcause", d, 32'd2);
    rd_csr(12'h343, d, ill, ill32); check_vec("exc_mtval", d, 32'hDEAD_BEEF);
    rd_csr(12'h300, d, ill, ill32); check_vec("exc_mstatus", d, 32'h0000_1880);

    // Vectored interrupt: timer beats local line 0
    wr_csr(12'h305, 32'h0000_0101, 2'b00, ill);
    wr_csr(12'h304, 32'h0001_0088, 2'b00, ill);
    rd_csr(12'h304, d, ill, ill32); check_vec("mie_mask", d, 32'h0001_0080);
    wr_csr(12'h300, 32'h0000_0008, 2'b01, ill);
    pc = 32'h80;
    @(negedge clk); irq_timer = 1'b1; irq_local = 4'b0001;
    #2;
    check_vec("irq_trap_taken", {31'b0, trap_taken}, 32'h1);
    check_vec("irq_trap_pc", trap_pc, 32'h0000_011C);
    @(posedge clk); #1 irq_timer = 1'b0; irq_local = '0;
    rd_csr(12'h342, d, ill, ill32); check_vec("irq_mcause", d, 32'h8000_0007);
    rd_csr(12'h341, d, ill, ill32); check_vec("irq_mepc", d, 32'h80);
    rd_csr(12'h300, d, ill, ill32); check_vec("irq_mstatus", d, 32'h0000_1880);

    // mret restores MIE
    @(negedge clk); mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    rd_csr(12'h300, d, ill, ill32); check_vec("mret_mstatus", d, 32'h0000_1888);
    check_vec("mret_csr_mepc", csr_mepc, 32'h80);

    // Exception edge together with a mepc write: trap wins
    pc = 32'hC0; exception_code = 8'd5;
    @(negedge clk);
    exception = 1'b1;
    bus.csr_addr = 12'h341; bus.csr_data_in = 32'hFFFF_FFFF; bus.csr_cntrl = 2'b00; bus.csr_wr = 1'b1;
    #2 check_vec("exc_wr_trap", {31'b0, trap_taken}, 32'h1);
    @(posedge clk); #1 bus.csr_wr = 1'b0; exception = 1'b0;
    rd_csr(12'h341, d, ill, ill32); check_vec("exc_wr_mepc", d, 32'hC0);
    rd_csr(12'h343, d, ill, ill32); check_vec("exc5_mtval", d, 32'h0);

    // Exception edge together with a mscratch write: write completes
    pc = 32'hC4;
    @(negedge clk);
    exception = 1'b1;
    bus.csr_addr = 12'h340; bus.csr_data_in = 32'h0000_00A5; bus.csr_cntrl = 2'b00; bus.csr_wr = 1'b1;
    #2 check_vec("exc_scr_trap", {31'b0, trap_taken}, 32'h1);
    @(posedge clk); #1 bus.csr_wr = 1'b0; exception = 1'b0;
    rd_csr(12'h340, d, ill, ill32); check_vec("exc_scr_mscratch", d, 32'h0000_00A5);
    rd_csr(12'h341, d, ill, ill32); check_vec("exc_scr_mepc", d, 32'hC4);

    // Set / clear modes
    wr_csr(12'h340, 32'h0000_000F, 2'b01, ill);
    rd_csr(12'h340, d, ill, ill32); check_vec("mscratch_set", d, 32'h0000_00AF);
    wr_csr(12'h340, 32'h0000_00A0, 2'b10, ill);
    rd_csr(12'h340, d, ill, ill32); check_vec("mscratch_clr", d, 32'h0000_000F);

    // Illegal accesses and read-only CSRs
    rd_csr(12'h7C0, d, ill, ill32);
    check_vec("ill_rd_flag", {31'b0, ill}, 32'h1);
    check_vec("ill_rd_data", d, 32'h0);
    irq_ext = 1'b1;
    wr_csr(12'h344, 32'hFFFF_FFFF, 2'b00, ill);
    check_vec("ill_wr_mip", {31'b0, ill}, 32'h1);
    rd_csr(12'h344, d, ill, ill32); check_vec("mip_read", d, 32'h0000_0800);
    irq_ext = 1'b0;
    rd_csr(12'hF14, d, ill, ill32);
    check_vec("mhartid", d, 32'h0);
    check_vec("mhartid_legal", {31'b0, ill}, 32'h0);
    rd_csr(12'hB80, d, ill, ill32);
    check_vec("cnt32_mcycleh_ill", {31'b0, ill32}, 32'h1);
    check_vec("cnt64_mcycleh_legal", {31'b0, ill}, 32'h0);

    // Counter writes beat the increment
    instr_retire = 1'b1;
    wr_csr(12'hB02, 32'd5, 2'b00, ill);
    rd_csr(12'hB02, d, ill, ill32); check_vec("minstret_wr", d, 32'd5);
    instr_retire = 1'b0;
    rd_csr(12'hB02, d, ill, ill32); check_vec("minstret_inc", d, 32'd6);
    wr_csr(12'hB80, 32'h7, 2'b00, ill);
    rd_csr(12'hB80, d, ill, ill32); check_vec("mcycleh_wr", d, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
